// File: rtl/onchip_ram_avalon_ctrl.sv
// Parametrised single-port on-chip RAM behind an Avalon-MM slave port.
// The read latency is 1 or 2 cycles, qualified by readdatavalid. A clear
// engine fills the array with CLEAR_VALUE after reset or when clear_req is
// pulsed. While the engine runs, it holds waitrequest high.
`timescale 1ns/1ps
module onchip_ram_avalon_ctrl #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 10,
  parameter int                    DEPTH          = 1024,
  parameter int                    READ_LATENCY   = 1,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  input  logic                    clear_req,
  output logic                    clear_busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic                  clearing;
  logic                  in_range;
  logic                  accept;
  logic                  rd_go;
  logic                  wr_go;
  logic                  clear_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] data1;
  logic                  rd_v1_q, rd_v1_d;
  logic                  oor1_q, oor1_d;

  assign clearing = (state_q == ST_CLEAR);
  // Addresses beyond DEPTH are decoded here so that writes drop and reads return zero.
  assign in_range = (32'(address) < DEPTH);
  assign waitrequest = ~reset | clearing | ~clken;
  assign clear_busy  = reset ? clearing : (CLEAR_ON_RESET != 0);
  assign accept   = chipselect & (read | write) & ~waitrequest;
  // A write takes priority over a simultaneous read, and no read is issued.
  assign rd_go    = accept & read & ~write;
  assign wr_go    = accept & write;
  assign clear_we = clearing & clken & reset;
  // Commands and the clear engine never overlap, so one address mux serves the port.
  assign mem_idx  = clearing ? cnt_q : address[IDX_W-1:0];

  // Next-state logic for the clear engine. Nothing advances while clken is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clken) begin
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == IDX_W'(DEPTH - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and counter registers. Reset restarts or abandons the clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Each byte lane is its own array, so byteenable maps onto independent write enables.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;
      logic       lane_we;
      logic [7:0] lane_wdata;

      assign lane_we    = clear_we | (wr_go & byteenable[gi] & in_range);
      assign lane_wdata = clearing ? CLEAR_VALUE[gi*8 +: 8] : writedata[gi*8 +: 8];

      // Array write port for this lane.
      always_ff @(posedge clk) begin
        if (lane_we) begin
          mem[mem_idx] <= lane_wdata;
        end
      end

      // Registered read for this lane. The register holds its value between reads.
      always_ff @(posedge clk) begin
        if (!reset) begin
          rd_q <= '0;
        end else if (clken && rd_go) begin
          rd_q <= mem[mem_idx];
        end
      end

      assign ram_q[gi*8 +: 8] = rd_q;
    end
  endgenerate

  // First read stage: valid flag and out-of-range marker. Both freeze when clken is low.
  always_comb begin
    rd_v1_d = clken ? rd_go : rd_v1_q;
    oor1_d  = (clken && rd_go) ? ~in_range : oor1_q;
  end

  // First-stage pipeline registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_v1_q <= 1'b0;
      oor1_q  <= 1'b0;
    end else begin
      rd_v1_q <= rd_v1_d;
      oor1_q  <= oor1_d;
    end
  end

  assign data1 = oor1_q ? '0 : ram_q;

  generate
    if (READ_LATENCY == 2) begin : g_rl2
      logic                  rd_v2_q, rd_v2_d;
      logic [DATA_WIDTH-1:0] rd_d2_q, rd_d2_d;

      // Optional output register stage. It also holds its value while clken is low.
      always_comb begin
        rd_v2_d = clken ? rd_v1_q : rd_v2_q;
        rd_d2_d = clken ? data1   : rd_d2_q;
      end

      // Output register stage.
      always_ff @(posedge clk) begin
        if (!reset) begin
          rd_v2_q <= 1'b0;
          rd_d2_q <= '0;
        end else begin
          rd_v2_q <= rd_v2_d;
          rd_d2_q <= rd_d2_d;
        end
      end

      assign readdatavalid = rd_v2_q;
      assign readdata      = rd_d2_q;
    end else begin : g_rl1
      assign readdatavalid = rd_v1_q;
      assign readdata      = data1;
    end
  endgenerate

endmodule

// File: tb/tb_onchip_ram_avalon_ctrl.sv
// Testbench for onchip_ram_avalon_ctrl. Two instances share the same stimulus:
// u_dut1 uses READ_LATENCY=1 and u_dut2 uses READ_LATENCY=2. Both use DEPTH=16.
`timescale 1ns/1ps
module tb_onchip_ram_avalon_ctrl;

  localparam logic [31:0] CV = 32'h5A5A_A5A5;

  logic        clk;
  logic        rst_n;
  logic        clken;
  logic [4:0]  addr;
  logic [3:0]  be;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [31:0] wd;
  logic        clr;
  logic [31:0] rdata1, rdata2;
  logic        rdv1, rdv2, wreq1, wreq2, busy1, busy2;

  int checks = 0;
  int errors = 0;
  int n;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [4:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_v;
    logic [31:0] exp_d;
  } vec_t;

  vec_t        vecs[$];
  vec_t        v;
  logic        prev_v;
  logic [31:0] prev_d;

  onchip_ram_avalon_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .READ_LATENCY(1),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
  ) u_dut1 (
    .clk(clk), .reset(rst_n), .clken(clken), .address(addr), .byteenable(be),
    .chipselect(cs), .read(rd), .write(wr), .writedata(wd), .readdata(rdata1),
    .readdatavalid(rdv1), .waitrequest(wreq1), .clear_req(clr), .clear_busy(busy1)
  );

  onchip_ram_avalon_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .READ_LATENCY(2),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
  ) u_dut2 (
    .clk(clk), .reset(rst_n), .clken(clken), .address(addr), .byteenable(be),
    .chipselect(cs), .read(rd), .write(wr), .writedata(wd), .readdata(rdata2),
    .readdatavalid(rdv2), .waitrequest(wreq2), .clear_req(clr), .clear_busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    rd   = r;
    wr   = w;
    cs   = r | w;
    addr = a;
    be   = b;
    wd   = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 4'h0, 32'h0);
  endtask

  // Single read: check the 1-cycle instance, then the 2-cycle instance.
  task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, a, 4'hF, 32'h0);
    step();
    idle();
    check1({name, "_rdv1"}, rdv1, 1'b1);
    check({name, "_rdata1"}, rdata1, exp);
    step();
    check1({name, "_rdv2"}, rdv2, 1'b1);
    check({name, "_rdata2"}, rdata2, exp);
    check1({name, "_rdv1_drop"}, rdv1, 1'b0);
    $display("read %s addr=%0d rdata1=%h rdata2=%h", name, a, rdata1, rdata2);
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [4:0] a,
                              input logic [3:0] b, input logic [31:0] d,
                              input logic ev, input logic [31:0] ed);
    vec_t t;
    t.rd = r; t.wr = w; t.addr = a; t.be = b; t.wdata = d; t.exp_v = ev; t.exp_d = ed;
    return t;
  endfunction

  initial begin
    // Each entry's expected values are the u_dut1 outputs after its clock edge.
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1'b1, 1'b0, 5'(i), 4'hF, 32'h0, 1'b1, CV));
    vecs.push_back(mk(1'b0, 1'b1, 5'd5,  4'hF, 32'hDEADBEEF, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 5'd5,  4'h1, 32'h00000011, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 5'd5,  4'hF, 32'h0,        1'b1, 32'hDEADBE11));
    vecs.push_back(mk(1'b0, 1'b1, 5'd1,  4'hF, 32'h00000010, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 5'd2,  4'hF, 32'h00000020, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 5'd3,  4'hF, 32'h00000030, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 5'd4,  4'hF, 32'h00000040, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 5'd1,  4'hF, 32'h0,        1'b1, 32'h00000010));
    vecs.push_back(mk(1'b1, 1'b0, 5'd2,  4'hF, 32'h0,        1'b1, 32'h00000020));
    vecs.push_back(mk(1'b1, 1'b0, 5'd3,  4'hF, 32'h0,        1'b1, 32'h00000030));
    vecs.push_back(mk(1'b1, 1'b0, 5'd4,  4'hF, 32'h0,        1'b1, 32'h00000040));
    vecs.push_back(mk(1'b1, 1'b0, 5'd20, 4'hF, 32'h0,        1'b1, 32'h00000000));
    vecs.push_back(mk(1'b0, 1'b1, 5'd20, 4'hF, 32'h12345678, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 5'd4,  4'hF, 32'h0,        1'b1, 32'h00000040));
    vecs.push_back(mk(1'b1, 1'b1, 5'd7,  4'hF, 32'h00000077, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 5'd7,  4'hF, 32'h0,        1'b1, 32'h00000077));
    vecs.push_back(mk(1'b0, 1'b1, 5'd7,  4'h0, 32'hFFFFFFFF, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 5'd7,  4'h0, 32'h0,        1'b1, 32'h00000077));
    vecs.push_back(mk(1'b0, 1'b1, 5'd9,  4'hC, 32'hAABBCCDD, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 5'd9,  4'hF, 32'h0,        1'b1, 32'hAABBA5A5));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0,  4'h0, 32'h0,        1'b0, 32'h0));

    // Hold reset for a few cycles, then check the reset state.
    rst_n = 1'b0; clken = 1'b1; clr = 1'b0;
    idle();
    repeat (3) step();
    check1("rst_rdv1", rdv1, 1'b0);
    check("rst_rdata1", rdata1, 32'h0);
    check1("rst_rdv2", rdv2, 1'b0);
    check("rst_rdata2", rdata2, 32'h0);
    check1("rst_wreq", wreq1, 1'b1);
    check1("rst_busy1", busy1, 1'b1);
    check1("rst_busy2", busy2, 1'b1);

    // After release, the automatic clear should hold busy for exactly DEPTH cycles.
    rst_n = 1'b1;
    #1;
    n = 0;
    while (busy1 && n < 100) begin
      n++;
      if (n == 3) check1("init_clr_wreq", wreq1, 1'b1);
      step();
    end
    check("init_clear_len", n, 16);
    check1("init_wreq_idle", wreq1, 1'b0);
    check1("init_busy2_idle", busy2, 1'b0);
    $display("init clear took %0d cycles", n);

    // Table vectors. u_dut2 should lag the expected u_dut1 outputs by one cycle.
    prev_v = 1'b0;
    prev_d = 32'h0;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rd, v.wr, v.addr, v.be, v.wdata);
      #1;
      check1($sformatf("vec%0d_wreq", i), wreq1, 1'b0);
      step();
      check1($sformatf("vec%0d_rdv1", i), rdv1, v.exp_v);
      if (v.exp_v) check($sformatf("vec%0d_rdata1", i), rdata1, v.exp_d);
      check1($sformatf("vec%0d_rdv2", i), rdv2, prev_v);
      if (prev_v) check($sformatf("vec%0d_rdata2", i), rdata2, prev_d);
      $display("vec %0d rd=%0b wr=%0b addr=%0d be=%h wd=%h rdv1=%0b rdata1=%h rdv2=%0b rdata2=%h",
               i, v.rd, v.wr, v.addr, v.be, v.wdata, rdv1, rdata1, rdv2, rdata2);
      prev_v = v.exp_v;
      prev_d = v.exp_d;
    end

    // Burst of reads with clken dropped for 3 cycles after the second read.
    drive(1'b1, 1'b0, 5'd1, 4'hF, 32'h0);
    step();
    check1("burst_a_rdv1", rdv1, 1'b1); check("burst_a_rdata1", rdata1, 32'h10);
    check1("burst_a_rdv2", rdv2, 1'b0);
    drive(1'b1, 1'b0, 5'd2, 4'hF, 32'h0);
    step();
    check1("burst_b_rdv1", rdv1, 1'b1); check("burst_b_rdata1", rdata1, 32'h20);
    check1("burst_b_rdv2", rdv2, 1'b1); check("burst_b_rdata2", rdata2, 32'h10);
    clken = 1'b0;
    drive(1'b1, 1'b0, 5'd3, 4'hF, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check1($sformatf("freeze%0d_wreq", k), wreq1, 1'b1);
      step();
      check1($sformatf("freeze%0d_rdv1", k), rdv1, 1'b1);
      check($sformatf("freeze%0d_rdata1", k), rdata1, 32'h20);
      check1($sformatf("freeze%0d_rdv2", k), rdv2, 1'b1);
      check($sformatf("freeze%0d_rdata2", k), rdata2, 32'h10);
      $display("freeze %0d rdv1=%0b rdata1=%h rdv2=%0b rdata2=%h", k, rdv1, rdata1, rdv2, rdata2);
    end
    clken = 1'b1;
    step();
    check1("burst_c_rdv1", rdv1, 1'b1); check("burst_c_rdata1", rdata1, 32'h30);
    check1("burst_c_rdv2", rdv2, 1'b1); check("burst_c_rdata2", rdata2, 32'h20);
    drive(1'b1, 1'b0, 5'd4, 4'hF, 32'h0);
    step();
    check1("burst_d_rdv1", rdv1, 1'b1); check("burst_d_rdata1", rdata1, 32'h40);
    check1("burst_d_rdv2", rdv2, 1'b1); check("burst_d_rdata2", rdata2, 32'h30);
    idle();
    step();
    check1("burst_e_rdv1", rdv1, 1'b0);
    check1("burst_e_rdv2", rdv2, 1'b1); check("burst_e_rdata2", rdata2, 32'h40);
    step();
    check1("burst_f_rdv2", rdv2, 1'b0);

    // Pulse clear_req in the same cycle as an accepted read of addr 3.
    drive(1'b0, 1'b1, 5'd3, 4'hF, 32'h000000AA);
    step();
    drive(1'b1, 1'b0, 5'd3, 4'hF, 32'h0);
    clr = 1'b1;
    #1;
    check1("clrrd_wreq", wreq1, 1'b0);
    step();
    clr = 1'b0;
    idle();
    check1("clrrd_rdv1", rdv1, 1'b1); check("clrrd_rdata1", rdata1, 32'hAA);
    check1("clrrd_busy1", busy1, 1'b1); check1("clrrd_busy2", busy2, 1'b1);
    step();
    check1("clrrd_rdv2", rdv2, 1'b1); check("clrrd_rdata2", rdata2, 32'hAA);
    check1("clrrd_rdv1_drop", rdv1, 1'b0);
    n = 1;
    while (busy1 && n < 100) begin
      n++;
      if (n == 3) check1("clr_wreq", wreq1, 1'b1);
      clr = (n == 6);
      step();
      clr = 1'b0;
    end
    check("req_clear_len", n, 16);
    check1("req_busy2_idle", busy2, 1'b0);
    $display("requested clear took %0d cycles", n);
    read_check("post_clr3", 5'd3, CV);
    read_check("post_clr15", 5'd15, CV);

    // Assert reset partway through a clear. The clear must restart from address 0.
    drive(1'b0, 1'b1, 5'd15, 4'hF, 32'h00000099);
    step();
    idle();
    read_check("pre_rst15", 5'd15, 32'h99);
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (6) step();
    rst_n = 1'b0;
    step();
    step();
    check1("midrst_busy", busy1, 1'b1);
    check1("midrst_wreq", wreq1, 1'b1);
    check1("midrst_rdv1", rdv1, 1'b0);
    rst_n = 1'b1;
    #1;
    n = 0;
    while (busy1 && n < 100) begin
      n++;
      step();
    end
    check("restart_clear_len", n, 16);
    $display("restarted clear took %0d cycles", n);
    read_check("post_rst15", 5'd15, CV);
    read_check("post_rst0", 5'd0, CV);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
